// File: rtl/isu_pkg.sv
// Shared ISU rename-stage constants and types.
package isu_pkg;
  localparam int unsigned NUM_PREG_DEF  = 64;
  localparam int unsigned NUM_RD_DEF    = 4;
  localparam int unsigned NUM_ALLOC_DEF = 2;
  localparam int unsigned NUM_WAKE_DEF  = 4;
  localparam int unsigned NUM_CKPT_DEF  = 8;

  localparam int unsigned PREG_W = $clog2(NUM_PREG_DEF);
  localparam int unsigned CKPT_W = $clog2(NUM_CKPT_DEF);

  typedef logic [PREG_W-1:0] preg_id_t;
endpackage

// File: rtl/busy_ckpt_queue.sv
// Circular queue of busy-table snapshots with head/tail pointers and wakeup scrubbing.
module busy_ckpt_queue
  import isu_pkg::*;
#(
  parameter int unsigned NUM_PREG = NUM_PREG_DEF,
  parameter int unsigned NUM_CKPT = NUM_CKPT_DEF,
  localparam int unsigned CKPT_W = $clog2(NUM_CKPT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_PREG-1:0] busy_next,
  input  logic [NUM_PREG-1:0] wmask,
  input  logic                ckpt_req,
  input  logic                ckpt_release,
  input  logic                restore_en,
  input  logic [CKPT_W-1:0]   restore_id,
  input  logic                flush_all,
  output logic [NUM_PREG-1:0] restore_vec,
  output logic                ckpt_ready,
  output logic [CKPT_W-1:0]   ckpt_id,
  output logic [CKPT_W:0]     ckpt_count
);
  localparam logic [CKPT_W:0] FULL = (CKPT_W+1)'(NUM_CKPT);
  localparam logic [CKPT_W:0] ONE  = (CKPT_W+1)'(1);

  logic [NUM_PREG-1:0] ckpt_mem [NUM_CKPT];
  logic [CKPT_W:0]     head, tail;
  logic [CKPT_W-1:0]   rst_off;
  logic [CKPT_W:0]     tail_rst;
  logic                take;

  assign ckpt_count  = tail - head;
  assign ckpt_ready  = (ckpt_count != FULL);
  assign ckpt_id     = tail[CKPT_W-1:0];
  assign take        = ckpt_req && ckpt_ready && !restore_en && !flush_all;
  assign restore_vec = ckpt_mem[restore_id];

  // Restored tail is head plus the slot's distance from head, so the wrap bit follows head.
  assign rst_off  = restore_id - head[CKPT_W-1:0];
  assign tail_rst = head + {1'b0, rst_off};

  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
    end else if (flush_all) begin
      head <= tail;
    end else begin
      if (restore_en)  tail <= tail_rst;
      else if (take)   tail <= tail + ONE;
      if (ckpt_release) head <= head + ONE;
    end
  end

  // Every slot, live or not, drops completed writebacks so a later restore stays current.
  always_ff @(posedge clk) begin
    for (int unsigned j = 0; j < NUM_CKPT; j++) begin
      if (take && (tail[CKPT_W-1:0] == CKPT_W'(j))) ckpt_mem[j] <= busy_next;
      else                                           ckpt_mem[j] <= ckpt_mem[j] & ~wmask;
    end
  end

  a_release_empty: assert property (@(posedge clk) disable iff (reset)
    !(ckpt_release && !flush_all && (ckpt_count == '0)));
  a_restore_release_head: assert property (@(posedge clk) disable iff (reset)
    !(restore_en && !flush_all && ckpt_release && (restore_id == head[CKPT_W-1:0])));
  a_restore_range: assert property (@(posedge clk) disable iff (reset)
    !(restore_en && !flush_all && ({1'b0, rst_off} >= ckpt_count)));
endmodule

// File: rtl/busy_table_ckpt.sv
// Physical-register busy table with bypassed dispatch reads and checkpoint restore.
module busy_table_ckpt
  import isu_pkg::*;
#(
  parameter int unsigned NUM_PREG  = NUM_PREG_DEF,
  parameter int unsigned NUM_RD    = NUM_RD_DEF,
  parameter int unsigned NUM_ALLOC = NUM_ALLOC_DEF,
  parameter int unsigned NUM_WAKE  = NUM_WAKE_DEF,
  parameter int unsigned NUM_CKPT  = NUM_CKPT_DEF,
  localparam int unsigned PREG_W = $clog2(NUM_PREG),
  localparam int unsigned CKPT_W = $clog2(NUM_CKPT)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_RD*PREG_W-1:0]      rd_addr,
  output logic [NUM_RD-1:0]             rd_busy,
  input  logic [NUM_ALLOC-1:0]          alloc_en,
  input  logic [NUM_ALLOC*PREG_W-1:0]   alloc_addr,
  input  logic [NUM_WAKE-1:0]           wake_en,
  input  logic [NUM_WAKE*PREG_W-1:0]    wake_addr,
  input  logic                          ckpt_req,
  output logic                          ckpt_ready,
  output logic [CKPT_W-1:0]             ckpt_id,
  input  logic                          ckpt_release,
  input  logic                          restore_en,
  input  logic [CKPT_W-1:0]             restore_id,
  input  logic                          flush_all,
  output logic [CKPT_W:0]               ckpt_count,
  output logic [NUM_PREG-1:0]           busy_vec
);
  logic [NUM_PREG-1:0] busy_q, busy_next, wmask, amask, restore_vec;
  logic                ctrl_override;

  assign ctrl_override = restore_en | flush_all;

  always_comb begin
    wmask = '0;
    amask = '0;
    for (int unsigned i = 0; i < NUM_WAKE; i++)
      if (wake_en[i]) wmask[wake_addr[i*PREG_W +: PREG_W]] = 1'b1;
    for (int unsigned i = 0; i < NUM_ALLOC; i++)
      if (alloc_en[i]) amask[alloc_addr[i*PREG_W +: PREG_W]] = 1'b1;
  end

  assign busy_next = (busy_q & ~wmask) | amask;

  always_comb begin : bypass
    logic [PREG_W-1:0] addr;
    logic              a_hit, w_hit;
    rd_busy = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      addr  = rd_addr[k*PREG_W +: PREG_W];
      a_hit = 1'b0;
      w_hit = 1'b0;
      for (int unsigned i = 0; i < NUM_ALLOC; i++)
        if (alloc_en[i] && (alloc_addr[i*PREG_W +: PREG_W] == addr)) a_hit = 1'b1;
      for (int unsigned i = 0; i < NUM_WAKE; i++)
        if (wake_en[i] && (wake_addr[i*PREG_W +: PREG_W] == addr)) w_hit = 1'b1;
      rd_busy[k] = (a_hit && !ctrl_override) || (!w_hit && busy_q[addr]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)           busy_q <= '0;
    else if (flush_all)  busy_q <= '0;
    else if (restore_en) busy_q <= restore_vec & ~wmask;
    else                 busy_q <= busy_next;
  end

  assign busy_vec = busy_q;

  busy_ckpt_queue #(
    .NUM_PREG (NUM_PREG),
    .NUM_CKPT (NUM_CKPT)
  ) u_queue (
    .clk          (clk),
    .reset        (reset),
    .busy_next    (busy_next),
    .wmask        (wmask),
    .ckpt_req     (ckpt_req),
    .ckpt_release (ckpt_release),
    .restore_en   (restore_en),
    .restore_id   (restore_id),
    .flush_all    (flush_all),
    .restore_vec  (restore_vec),
    .ckpt_ready   (ckpt_ready),
    .ckpt_id      (ckpt_id),
    .ckpt_count   (ckpt_count)
  );

  a_alloc_wake_collide: assert property (@(posedge clk) disable iff (reset)
    ((amask & wmask) == '0));
endmodule

// File: tb/tb_busy_table_ckpt.sv
// Directed bench for busy_table_ckpt: bypass, checkpoint queue, restore, flush, reset.
module tb_busy_table_ckpt;
  import isu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] rd_addr;
  logic [3:0]  rd_busy;
  logic [1:0]  alloc_en;
  logic [11:0] alloc_addr;
  logic [3:0]  wake_en;
  logic [23:0] wake_addr;
  logic        ckpt_req, ckpt_ready, ckpt_release, restore_en, flush_all;
  logic [2:0]  ckpt_id, restore_id;
  logic [3:0]  ckpt_count;
  logic [63:0] busy_vec;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  busy_table_ckpt #(
    .NUM_PREG  (64),
    .NUM_RD    (4),
    .NUM_ALLOC (2),
    .NUM_WAKE  (4),
    .NUM_CKPT  (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rd_addr      (rd_addr),
    .rd_busy      (rd_busy),
    .alloc_en     (alloc_en),
    .alloc_addr   (alloc_addr),
    .wake_en      (wake_en),
    .wake_addr    (wake_addr),
    .ckpt_req     (ckpt_req),
    .ckpt_ready   (ckpt_ready),
    .ckpt_id      (ckpt_id),
    .ckpt_release (ckpt_release),
    .restore_en   (restore_en),
    .restore_id   (restore_id),
    .flush_all    (flush_all),
    .ckpt_count   (ckpt_count),
    .busy_vec     (busy_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle();
    alloc_en = '0; alloc_addr = '0; wake_en = '0; wake_addr = '0;
    ckpt_req = 1'b0; ckpt_release = 1'b0; restore_en = 1'b0; restore_id = '0;
    flush_all = 1'b0; rd_addr = '0;
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input int unsigned port, input preg_id_t p);
    alloc_en[port] = 1'b1;
    alloc_addr[port*6 +: 6] = p;
  endtask

  task automatic do_wake(input int unsigned port, input preg_id_t p);
    wake_en[port] = 1'b1;
    wake_addr[port*6 +: 6] = p;
  endtask

  task automatic set_rd(input int unsigned port, input preg_id_t p);
    rd_addr[port*6 +: 6] = p;
  endtask

  function automatic logic [63:0] bit64(input int unsigned n);
    logic [63:0] v;
    v = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_busy",  busy_vec,   64'd0);
    check("rst_count", ckpt_count, 64'd0);
    check("rst_ready", ckpt_ready, 64'd1);
    check("rst_id",    ckpt_id,    64'd0);

    // Same-cycle bypass: alloc p5 wins, wake p9 hides the stored busy bit.
    do_alloc(0, 6'd9);
    tick(); idle();
    check("pre_b9", busy_vec[9], 64'd1);
    do_alloc(0, 6'd5); do_wake(0, 6'd9);
    set_rd(0, 6'd5); set_rd(1, 6'd9); set_rd(2, 6'd20); set_rd(3, 6'd9);
    #1;
    check("byp_rd", rd_busy, 64'b0001);
    tick(); idle();
    check("byp_vec", busy_vec, bit64(5));
    do_wake(1, 6'd5);
    tick(); idle();
    check("clean_vec", busy_vec, 64'd0);

    // Snapshot includes same-cycle alloc; later wake scrubs it before restore.
    do_alloc(0, 6'd3); ckpt_req = 1'b1;
    #1;
    check("c0_id", ckpt_id, 64'd0);
    tick(); idle();
    check("c0_count", ckpt_count, 64'd1);
    do_alloc(1, 6'd7);
    tick(); idle();
    check("c0_busy37", busy_vec, bit64(3) | bit64(7));
    do_wake(2, 6'd3);
    tick(); idle();
    restore_en = 1'b1; restore_id = 3'd0;
    do_alloc(0, 6'd9); set_rd(0, 6'd9);
    #1;
    check("rs_mask_alloc", rd_busy[0], 64'd0);
    tick(); idle();
    check("rs0_busy",  busy_vec,   64'd0);
    check("rs0_count", ckpt_count, 64'd0);
    check("rs0_id",    ckpt_id,    64'd0);

    // Fill all 8 slots, slot i holds p20..p(20+i).
    for (int i = 0; i < 8; i++) begin
      ckpt_req = 1'b1; do_alloc(0, 6'(20 + i));
      tick(); idle();
    end
    check("full_count", ckpt_count, 64'd8);
    check("full_ready", ckpt_ready, 64'd0);
    ckpt_req = 1'b1; do_alloc(0, 6'd40);
    tick(); idle();
    check("full_ign_count", ckpt_count, 64'd8);
    check("full_ign_id",    ckpt_id,    64'd0);
    ckpt_release = 1'b1;
    tick(); idle();
    check("rel_ready", ckpt_ready, 64'd1);
    check("rel_id",    ckpt_id,    64'd0);
    check("rel_count", ckpt_count, 64'd7);

    // Restore slot 3 with a same-cycle wake of p21.
    restore_en = 1'b1; restore_id = 3'd3; do_wake(0, 6'd21);
    tick(); idle();
    check("rs3_busy",  busy_vec,   bit64(20) | bit64(22) | bit64(23));
    check("rs3_count", ckpt_count, 64'd2);
    check("rs3_id",    ckpt_id,    64'd3);

    // Grow to 5 live checkpoints, then flush during an alloc of p12.
    for (int i = 0; i < 3; i++) begin
      ckpt_req = 1'b1;
      tick(); idle();
    end
    check("pf_count", ckpt_count, 64'd5);
    flush_all = 1'b1; do_alloc(0, 6'd12); ckpt_req = 1'b1; set_rd(0, 6'd12);
    #1;
    check("fl_rd12", rd_busy[0], 64'd0);
    tick(); idle();
    check("fl_busy",  busy_vec,   64'd0);
    check("fl_count", ckpt_count, 64'd0);
    check("fl_ready", ckpt_ready, 64'd1);
    check("fl_id",    ckpt_id,    64'd6);

    // Four checkpoints wrapping over slot 7 -> 0; restore slot 0 with release.
    for (int i = 0; i < 4; i++) begin
      ckpt_req = 1'b1; do_alloc(1, 6'(50 + i));
      tick(); idle();
    end
    check("w_count", ckpt_count, 64'd4);
    check("w_id",    ckpt_id,    64'd2);
    restore_en = 1'b1; restore_id = 3'd0; ckpt_release = 1'b1;
    tick(); idle();
    check("wr_busy",  busy_vec,   bit64(50) | bit64(51) | bit64(52));
    check("wr_count", ckpt_count, 64'd1);
    check("wr_id",    ckpt_id,    64'd0);
    ckpt_release = 1'b1;
    tick(); idle();
    check("wr_rel_count", ckpt_count, 64'd0);

    // Reset overrides an in-flight restore.
    ckpt_req = 1'b1; do_alloc(0, 6'd60);
    tick(); idle();
    restore_en = 1'b1; restore_id = 3'd0; reset = 1'b1;
    tick(); idle();
    reset = 1'b0;
    set_rd(0, 6'd50); set_rd(1, 6'd60);
    #1;
    check("rr_busy",  busy_vec,   64'd0);
    check("rr_count", ckpt_count, 64'd0);
    check("rr_ready", ckpt_ready, 64'd1);
    check("rr_id",    ckpt_id,    64'd0);
    check("rr_rd",    rd_busy,    64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
